pic_cmd_sequencer: RTL and testbench

//  ICW/OCW command sequencer of the 8259-style PIC. Sits directly downstream of the read/write control logic and data bus buffer.

---
 rtl/pic_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pic_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_cmd_sequencer.sv
// ICW/OCW command sequencer for an 8259-style PIC.
// Walks the ICW1..ICW4 init sequence, holds the OCW1 mask, decodes OCW2/OCW3
// into strobes/flags and returns IMR/IRR/ISR status bytes on reads.
// Strobe semantics: wr_stb/rd_stb are single-cycle, already qualified
// upstream; each is consumed on the clk edge that samples it, there is no
// back-pressure, and a write wins over a simultaneous read (the read is dropped).
module pic_cmd_sequencer #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] IMR_RST = 8'hFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_stb,
  input  logic              rd_stb,
  input  logic              a0,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] irr,
  input  logic [DATA_W-1:0] isr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              icw1_stb,
  output logic              ltim,
  output logic              adi,
  output logic              sngl,
  output logic              ic4,
  output logic [4:0]        vec_base,
  output logic [DATA_W-1:0] icw3,
  output logic              aeoi,
  output logic              sfnm,
  output logic              bufm,
  output logic              msl,
  output logic              upm,
  output logic [DATA_W-1:0] imr,
  output logic              ocw2_stb,
  output logic [2:0]        ocw2_cmd,
  output logic [2:0]        ocw2_lvl,
  output logic              smm,
  output logic              rd_isr,
  output logic              poll_stb,
  output logic              init_busy,
  output logic              init_done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_UNINIT    = 3'd0,
    S_WAIT_ICW2 = 3'd1,
    S_WAIT_ICW3 = 3'd2,
    S_WAIT_ICW4 = 3'd3,
    S_READY     = 3'd4
  } state_t;

  state_t r_state;
  logic   w_is_icw1;

  // ICW1 is recognised in every state and always restarts the sequence
  assign w_is_icw1 = ~a0 & din[4];

  // Busy flag and debug state are plain decodes of the state register
  assign init_busy = (r_state == S_WAIT_ICW2) || (r_state == S_WAIT_ICW3) ||
                     (r_state == S_WAIT_ICW4);
  assign dbg_state = r_state;

  // Command FSM with all configuration, strobe and read-back registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_UNINIT;
      dout      <= '0;
      dout_vld  <= 1'b0;
      icw1_stb  <= 1'b0;
      ltim      <= 1'b0;
      adi       <= 1'b0;
      sngl      <= 1'b0;
      ic4       <= 1'b0;
      vec_base  <= '0;
      icw3      <= '0;
      aeoi      <= 1'b0;
      sfnm      <= 1'b0;
      bufm      <= 1'b0;
      msl       <= 1'b0;
      upm       <= 1'b0;
      imr       <= IMR_RST;
      ocw2_stb  <= 1'b0;
      ocw2_cmd  <= '0;
      ocw2_lvl  <= '0;
      smm       <= 1'b0;
      rd_isr    <= 1'b0;
      poll_stb  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      icw1_stb <= 1'b0;
      ocw2_stb <= 1'b0;
      poll_stb <= 1'b0;
      dout_vld <= 1'b0;
      if (wr_stb) begin
        if (w_is_icw1) begin
          ltim      <= din[3];
          adi       <= din[2];
          sngl      <= din[1];
          ic4       <= din[0];
          imr       <= '0;
          smm       <= 1'b0;
          rd_isr    <= 1'b0;
          icw3      <= '0;
          aeoi      <= 1'b0;
          sfnm      <= 1'b0;
          bufm      <= 1'b0;
          msl       <= 1'b0;
          upm       <= 1'b0;
          icw1_stb  <= 1'b1;
          init_done <= 1'b0;
          r_state   <= S_WAIT_ICW2;
        end else begin
          case (r_state)
            S_WAIT_ICW2: if (a0) begin
              vec_base <= din[DATA_W-1:3];
              if (!sngl) r_state <= S_WAIT_ICW3;
              else if (ic4) r_state <= S_WAIT_ICW4;
              else begin
                r_state   <= S_READY;
                init_done <= 1'b1;
              end
            end
            S_WAIT_ICW3: if (a0) begin
              icw3 <= din;
              if (ic4) r_state <= S_WAIT_ICW4;
              else begin
                r_state   <= S_READY;
                init_done <= 1'b1;
              end
            end
            S_WAIT_ICW4: if (a0) begin
              upm       <= din[0];
              aeoi      <= din[1];
              msl       <= din[2];
              bufm      <= din[3];
              sfnm      <= din[4];
              r_state   <= S_READY;
              init_done <= 1'b1;
            end
            S_READY: begin
              if (a0) begin
                imr <= din;
              end else if (din[4:3] == 2'b00) begin
                ocw2_stb <= 1'b1;
                ocw2_cmd <= din[7:5];
                ocw2_lvl <= din[2:0];
              end else if (din[4:3] == 2'b01) begin
                if (din[1]) rd_isr <= din[0];
                if (din[6]) smm <= din[5];
                if (din[2]) poll_stb <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end else if (rd_stb) begin
        dout     <= a0 ? imr : (rd_isr ? isr : irr);
        dout_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Bench for pic_cmd_sequencer: directed scenario tasks plus a read-data
// scoreboard (expected bytes queued when a read is issued, popped on dout_vld).
module tb_pic_cmd_sequencer;

  localparam logic [2:0] ST_UNINIT = 3'd0;
  localparam logic [2:0] ST_W2     = 3'd1;
  localparam logic [2:0] ST_W3     = 3'd2;
  localparam logic [2:0] ST_W4     = 3'd3;
  localparam logic [2:0] ST_READY  = 3'd4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_stb = 1'b0, rd_stb = 1'b0, a0 = 1'b0;
  logic [7:0] din = '0, irr = '0, isr = '0;
  logic [7:0] dout, icw3, imr;
  logic       dout_vld, icw1_stb, ltim, adi, sngl, ic4;
  logic [4:0] vec_base;
  logic       aeoi, sfnm, bufm, msl, upm, ocw2_stb, smm, rd_isr, poll_stb;
  logic [2:0] ocw2_cmd, ocw2_lvl, dbg_state;
  logic       init_busy, init_done;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  pic_cmd_sequencer dut (
    .clk(clk), .rstn(rstn), .wr_stb(wr_stb), .rd_stb(rd_stb), .a0(a0),
    .din(din), .irr(irr), .isr(isr), .dout(dout), .dout_vld(dout_vld),
    .icw1_stb(icw1_stb), .ltim(ltim), .adi(adi), .sngl(sngl), .ic4(ic4),
    .vec_base(vec_base), .icw3(icw3), .aeoi(aeoi), .sfnm(sfnm), .bufm(bufm),
    .msl(msl), .upm(upm), .imr(imr), .ocw2_stb(ocw2_stb), .ocw2_cmd(ocw2_cmd),
    .ocw2_lvl(ocw2_lvl), .smm(smm), .rd_isr(rd_isr), .poll_stb(poll_stb),
    .init_busy(init_busy), .init_done(init_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: entered and left at posedge+1
  task automatic do_wr(input logic a, input logic [7:0] d);
    wr_stb = 1'b1; a0 = a; din = d;
    @(posedge clk); #1;
    wr_stb = 1'b0;
  endtask

  task automatic do_rd(input logic a, input logic [7:0] exp_v);
    logic [7:0] e;
    exp_q.push_back(exp_v);
    rd_stb = 1'b1; a0 = a;
    @(posedge clk); #1;
    rd_stb = 1'b0;
    n_checks++;
    if (dout_vld !== 1'b1) begin n_errors++; $display("FAIL rd_vld got=%b exp=1", dout_vld); end
    e = exp_q.pop_front();
    n_checks++;
    if (dout !== e) begin n_errors++; $display("FAIL rd_data got=%h exp=%h", dout, e); end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    do_wr(1'b0, 8'h10);
    do_wr(1'b1, 8'h08);
    n_checks++;
    if (dbg_state !== ST_W3) begin n_errors++; $display("FAIL pre_rst_state got=%0d exp=%0d", dbg_state, ST_W3); end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== ST_UNINIT) begin n_errors++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_UNINIT); end
    n_checks++;
    if (imr !== 8'hFF) begin n_errors++; $display("FAIL rst_imr got=%h exp=FF", imr); end
    n_checks++;
    if ({init_busy, init_done, vec_base, icw3, sngl} !== '0) begin
      n_errors++; $display("FAIL rst_outs got=%b%b %h %h %b exp=0", init_busy, init_done, vec_base, icw3, sngl);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_icw4();
    do_wr(1'b0, 8'h13);
    n_checks++;
    if ({icw1_stb, sngl, ic4, init_busy, imr} !== {4'b1111, 8'h00}) begin
      n_errors++; $display("FAIL t2_icw1 got=%b%b%b%b %h exp=1111 00", icw1_stb, sngl, ic4, init_busy, imr);
    end
    do_wr(1'b1, 8'h20);
    n_checks++;
    if (vec_base !== 5'h04) begin n_errors++; $display("FAIL t2_vec got=%h exp=04", vec_base); end
    n_checks++;
    if (dbg_state !== ST_W4) begin n_errors++; $display("FAIL t2_w4 got=%0d exp=%0d", dbg_state, ST_W4); end
    do_wr(1'b1, 8'h03);
    n_checks++;
    if ({aeoi, upm, msl, bufm, sfnm} !== 5'b11000) begin
      n_errors++; $display("FAIL t2_icw4 got=%b%b%b%b%b exp=11000", aeoi, upm, msl, bufm, sfnm);
    end
    n_checks++;
    if ({dbg_state, init_done, init_busy} !== {ST_READY, 2'b10}) begin
      n_errors++; $display("FAIL t2_ready got=%0d %b%b exp=4 10", dbg_state, init_done, init_busy);
    end
  endtask

  task automatic test_cascade();
    do_wr(1'b0, 8'h10);
    do_wr(1'b1, 8'h08);
    n_checks++;
    if ({dbg_state, vec_base} !== {ST_W3, 5'h01}) begin
      n_errors++; $display("FAIL t3_icw2 got=%0d %h exp=2 01", dbg_state, vec_base);
    end
    do_wr(1'b1, 8'h04);
    n_checks++;
    if (icw3 !== 8'h04) begin n_errors++; $display("FAIL t3_icw3 got=%h exp=04", icw3); end
    n_checks++;
    if ({dbg_state, init_done, aeoi, upm, msl, bufm, sfnm} !== {ST_READY, 6'b100000}) begin
      n_errors++; $display("FAIL t3_ready got=%0d %b %b%b%b%b%b exp=4 1 00000", dbg_state, init_done, aeoi, upm, msl, bufm, sfnm);
    end
  endtask

  task automatic test_restart();
    do_wr(1'b1, 8'h5A);
    n_checks++;
    if (imr !== 8'h5A) begin n_errors++; $display("FAIL t4_imr got=%h exp=5A", imr); end
    do_wr(1'b0, 8'h11);
    do_wr(1'b1, 8'h40);
    n_checks++;
    if (dbg_state !== ST_W3) begin n_errors++; $display("FAIL t4_w3 got=%0d exp=2", dbg_state); end
    do_wr(1'b0, 8'h11);
    n_checks++;
    if ({icw1_stb, dbg_state, imr, init_done, init_busy} !== {1'b1, ST_W2, 8'h00, 2'b01}) begin
      n_errors++; $display("FAIL t4_restart got=%b %0d %h %b%b exp=1 1 00 01", icw1_stb, dbg_state, imr, init_done, init_busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (icw1_stb !== 1'b0) begin n_errors++; $display("FAIL t4_pulse_width got=%b exp=0", icw1_stb); end
    // a0=0 non-ICW1 write mid-init is ignored
    do_wr(1'b0, 8'h20);
    n_checks++;
    if ({dbg_state, ocw2_stb} !== {ST_W2, 1'b0}) begin
      n_errors++; $display("FAIL t4_ignore got=%0d %b exp=1 0", dbg_state, ocw2_stb);
    end
  endtask

  task automatic test_ocw();
    logic [7:0] r;
    do_wr(1'b0, 8'h12);
    do_wr(1'b1, 8'h00);
    n_checks++;
    if (dbg_state !== ST_READY) begin n_errors++; $display("FAIL t5_ready got=%0d exp=4", dbg_state); end
    do_wr(1'b1, 8'hA5);
    n_checks++;
    if (imr !== 8'hA5) begin n_errors++; $display("FAIL t5_imr got=%h exp=A5", imr); end
    do_wr(1'b0, 8'h20);
    n_checks++;
    if ({ocw2_stb, ocw2_cmd, ocw2_lvl} !== {1'b1, 3'b001, 3'b000}) begin
      n_errors++; $display("FAIL t5_ocw2 got=%b %b %b exp=1 001 000", ocw2_stb, ocw2_cmd, ocw2_lvl);
    end
    do_wr(1'b0, 8'hE7);
    n_checks++;
    if ({ocw2_stb, ocw2_cmd, ocw2_lvl} !== {1'b1, 3'b111, 3'b111}) begin
      n_errors++; $display("FAIL t5_ocw2b got=%b %b %b exp=1 111 111", ocw2_stb, ocw2_cmd, ocw2_lvl);
    end
    do_wr(1'b0, 8'h0B);
    n_checks++;
    if ({rd_isr, ocw2_stb, poll_stb} !== 3'b100) begin
      n_errors++; $display("FAIL t5_rr got=%b%b%b exp=100", rd_isr, ocw2_stb, poll_stb);
    end
    isr = 8'h40; irr = 8'($urandom_range(0, 255));
    do_rd(1'b0, 8'h40);
    @(posedge clk); #1;
    n_checks++;
    if ({dout_vld, dout} !== {1'b0, 8'h40}) begin
      n_errors++; $display("FAIL t5_hold got=%b %h exp=0 40", dout_vld, dout);
    end
    do_wr(1'b0, 8'h68);
    n_checks++;
    if ({smm, rd_isr} !== 2'b11) begin n_errors++; $display("FAIL t5_smm got=%b%b exp=11", smm, rd_isr); end
    do_wr(1'b0, 8'h0C);
    n_checks++;
    if ({poll_stb, rd_isr, smm} !== 3'b111) begin
      n_errors++; $display("FAIL t5_poll got=%b%b%b exp=111", poll_stb, rd_isr, smm);
    end
    do_wr(1'b0, 8'h4A);
    n_checks++;
    if ({poll_stb, rd_isr, smm} !== 3'b000) begin
      n_errors++; $display("FAIL t5_rr_irr got=%b%b%b exp=000", poll_stb, rd_isr, smm);
    end
    r = 8'($urandom_range(0, 255));
    irr = r; isr = ~r;
    do_rd(1'b0, r);
  endtask

  task automatic test_collision();
    a0 = 1'b1; din = 8'h3C; wr_stb = 1'b1; rd_stb = 1'b1;
    @(posedge clk); #1;
    wr_stb = 1'b0; rd_stb = 1'b0;
    n_checks++;
    if ({imr, dout_vld} !== {8'h3C, 1'b0}) begin
      n_errors++; $display("FAIL t6_collide got=%h %b exp=3C 0", imr, dout_vld);
    end
    do_rd(1'b1, 8'h3C);
  endtask

  task automatic test_uninit();
    apply_reset();
    do_wr(1'b1, 8'h77);
    do_wr(1'b0, 8'h20);
    do_wr(1'b0, 8'h0B);
    n_checks++;
    if ({dbg_state, imr, ocw2_stb, rd_isr, init_done} !== {ST_UNINIT, 8'hFF, 3'b000}) begin
      n_errors++; $display("FAIL t6_uninit got=%0d %h %b%b%b exp=0 FF 000", dbg_state, imr, ocw2_stb, rd_isr, init_done);
    end
    do_rd(1'b1, 8'hFF);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    do_wr(1'b0, 8'h12);
    do_wr(1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom_range(0, 255));
      do_wr(1'b1, v);
      do_rd(1'b1, v);
    end
    // strobes on consecutive cycles with no idle gap
    v = 8'($urandom_range(0, 255));
    wr_stb = 1'b1; a0 = 1'b1; din = v;
    @(posedge clk); #1;
    din = 8'h60; a0 = 1'b0;
    @(posedge clk); #1;
    wr_stb = 1'b0;
    n_checks++;
    if ({imr, ocw2_stb, ocw2_cmd} !== {v, 1'b1, 3'b011}) begin
      n_errors++; $display("FAIL b2b_wr got=%h %b %b exp=%h 1 011", imr, ocw2_stb, ocw2_cmd, v);
    end
    exp_q.push_back(v);
    exp_q.push_back(irr);
    rd_stb = 1'b1; a0 = 1'b1;
    @(posedge clk); #1;
    a0 = 1'b0;
    n_checks++;
    if ({dout_vld, dout} !== {1'b1, exp_q.pop_front()}) begin
      n_errors++; $display("FAIL b2b_rd0 got=%b %h exp=1 %h", dout_vld, dout, v);
    end
    @(posedge clk); #1;
    rd_stb = 1'b0;
    n_checks++;
    if ({dout_vld, dout} !== {1'b1, exp_q.pop_front()}) begin
      n_errors++; $display("FAIL b2b_rd1 got=%b %h exp=1 %h", dout_vld, dout, irr);
    end
  endtask

  initial begin
    test_reset();
    test_single_icw4();
    test_cascade();
    test_restart();
    test_ocw();
    test_collision();
    test_uninit();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() !== 0) begin n_errors++; $display("FAIL sb_empty got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
